// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART <-> ALU framed command controller.
package alu_uart_pkg;

  // Controller states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_A   = 3'd1,
    S_GET_B   = 3'd2,
    S_GET_OP  = 3'd3,
    S_GET_CHK = 3'd4,
    S_EXEC    = 3'd5,
    S_SEND    = 3'd6,
    S_WAIT    = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hAA;
  localparam logic [7:0] RESP_BYTE   = 8'h55;
  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BADCHK   = 8'hE1;
  localparam logic [7:0] LED_TIMEOUT = 8'hEE;

  // Response frame byte for a given position: RESP, RESULT, STATUS.
  function automatic logic [7:0] resp_byte(input logic [1:0] idx,
                                           input logic [7:0] result,
                                           input logic [7:0] status);
    case (idx)
      2'd0:    resp_byte = RESP_BYTE;
      2'd1:    resp_byte = result;
      default: resp_byte = status;
    endcase
  endfunction

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled and
// flags expiry when the count has run out during an enabled cycle.
module frame_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] r_cnt;

  // Reload on clear; otherwise count down toward zero while enabled.
  always_ff @(posedge clk) begin
    if (!reset)                    r_cnt <= '0;
    else if (i_clr)                r_cnt <= LOAD;
    else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - W'(1);
  end

  // A zero count seen in an enabled cycle marks TIMEOUT_CYC idle cycles.
  assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/alu_frame_ctrl.sv
// Framed command controller: parses SYNC,A,B,OP,CHK from the UART,
// drives the ALU operands, and answers with RESP,RESULT,STATUS.
module alu_frame_ctrl
  import alu_uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] from_rx,
  input  logic       tx_done,
  input  logic [7:0] from_alu,
  output logic [7:0] num_a,
  output logic [7:0] num_b,
  output logic [7:0] opcode,
  output logic [7:0] to_tx,
  output logic       tx_start,
  output logic [7:0] leds,
  output logic       busy
);

  state_t     r_state, w_next;
  logic [7:0] r_stage_a, r_stage_b, r_stage_op;
  logic [7:0] r_num_a, r_num_b, r_opcode;
  logic [7:0] r_result, r_status, r_to_tx, r_leds;
  logic [1:0] r_idx;

  logic w_in_get, w_expire, w_to_clr;
  logic w_take_a, w_take_b, w_take_op, w_chk_ok, w_chk_bad;
  logic w_exec, w_adv, w_done, w_tmo;
  logic [7:0] w_chk;

  assign w_in_get = (r_state == S_GET_A) || (r_state == S_GET_B) ||
                    (r_state == S_GET_OP) || (r_state == S_GET_CHK);
  assign w_chk    = r_stage_a ^ r_stage_b ^ r_stage_op;

  frame_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_to_clr),
    .i_en     (w_in_get),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and datapath strobes; a byte arriving in the expiry cycle wins.
  always_comb begin
    w_next    = r_state;
    w_to_clr  = 1'b0;
    w_take_a  = 1'b0;
    w_take_b  = 1'b0;
    w_take_op = 1'b0;
    w_chk_ok  = 1'b0;
    w_chk_bad = 1'b0;
    w_exec    = 1'b0;
    w_adv     = 1'b0;
    w_done    = 1'b0;
    w_tmo     = 1'b0;
    case (r_state)
      S_IDLE: if (rx_done && from_rx == SYNC_BYTE) begin
        w_to_clr = 1'b1;
        w_next   = S_GET_A;
      end
      S_GET_A: if (rx_done) begin
        w_to_clr = 1'b1; w_take_a = 1'b1; w_next = S_GET_B;
      end else if (w_expire) begin
        w_tmo = 1'b1; w_next = S_IDLE;
      end
      S_GET_B: if (rx_done) begin
        w_to_clr = 1'b1; w_take_b = 1'b1; w_next = S_GET_OP;
      end else if (w_expire) begin
        w_tmo = 1'b1; w_next = S_IDLE;
      end
      S_GET_OP: if (rx_done) begin
        w_to_clr = 1'b1; w_take_op = 1'b1; w_next = S_GET_CHK;
      end else if (w_expire) begin
        w_tmo = 1'b1; w_next = S_IDLE;
      end
      S_GET_CHK: if (rx_done) begin
        w_to_clr = 1'b1;
        if (from_rx == w_chk) begin
          w_chk_ok = 1'b1; w_next = S_EXEC;
        end else begin
          w_chk_bad = 1'b1; w_next = S_SEND;
        end
      end else if (w_expire) begin
        w_tmo = 1'b1; w_next = S_IDLE;
      end
      S_EXEC: begin
        w_exec = 1'b1; w_next = S_SEND;
      end
      S_SEND: w_next = S_WAIT;
      S_WAIT: if (tx_done) begin
        if (r_idx == 2'd2) begin
          w_done = 1'b1; w_next = S_IDLE;
        end else begin
          w_adv = 1'b1; w_next = S_SEND;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: staging, operand commit, response byte load on entry to SEND.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stage_a  <= '0;
      r_stage_b  <= '0;
      r_stage_op <= '0;
      r_num_a    <= '0;
      r_num_b    <= '0;
      r_opcode   <= '0;
      r_result   <= '0;
      r_status   <= '0;
      r_to_tx    <= '0;
      r_leds     <= '0;
      r_idx      <= '0;
    end else begin
      if (w_take_a)  r_stage_a  <= from_rx;
      if (w_take_b)  r_stage_b  <= from_rx;
      if (w_take_op) r_stage_op <= from_rx;
      if (w_chk_ok) begin
        r_num_a  <= r_stage_a;
        r_num_b  <= r_stage_b;
        r_opcode <= r_stage_op;
        r_status <= ST_OK;
      end
      if (w_chk_bad) begin
        r_result <= 8'h00;
        r_status <= ST_BADCHK;
        r_idx    <= 2'd0;
        r_to_tx  <= RESP_BYTE;
      end
      if (w_exec) begin
        r_result <= from_alu;
        r_idx    <= 2'd0;
        r_to_tx  <= RESP_BYTE;
      end
      if (w_adv) begin
        r_idx   <= r_idx + 2'd1;
        r_to_tx <= resp_byte(r_idx + 2'd1, r_result, r_status);
      end
      if (w_done) r_leds <= (r_status == ST_OK) ? r_result : r_status;
      if (w_tmo)  r_leds <= LED_TIMEOUT;
    end
  end

  assign num_a    = r_num_a;
  assign num_b    = r_num_b;
  assign opcode   = r_opcode;
  assign to_tx    = r_to_tx;
  assign leds     = r_leds;
  assign tx_start = (r_state == S_SEND);
  assign busy     = (r_state != S_IDLE);

endmodule
